// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-enable divider bank.
package clk_div_pkg;

  localparam int DIV_OFF   = 0;
  localparam int DIV_PIX25 = 2;
  localparam int DIV_1KHZ  = 50000;
  localparam int DIV_AUDIO = 1134;

  // Channel-select width; a single channel still gets one select bit.
  function automatic int cfg_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider slice: counts 0..div-1 and emits a wrap tick plus a square-wave phase flag.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             load,
  input  logic             load_now,
  input  logic [CNT_W-1:0] new_div,
  output logic             tick,
  output logic             sq,
  output logic             wrap,
  output logic             idle
);

  logic [CNT_W-1:0] div_r, count_r, div_s, count_s;
  logic             tick_r, sq_r, tick_s, sq_s;
  logic [CNT_W:0]   half_s;

  // Next-state: sync beats immediate load, which beats halt and wrap.
  always_comb begin
    idle    = (div_r == CNT_W'(DIV_OFF));
    wrap    = !idle && (count_r == (div_r - CNT_W'(1)));
    half_s  = ({1'b0, div_r} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    div_s   = div_r;
    count_s = '0;
    tick_s  = 1'b0;
    sq_s    = 1'b0;
    if (sync) begin
      if (load || load_now) begin
        div_s = new_div;
      end else begin
        div_s = div_r;
      end
    end else if (load_now) begin
      div_s = new_div;
    end else if (idle) begin
      count_s = '0;
    end else if (wrap) begin
      tick_s = 1'b1;
      if (load) begin
        div_s = new_div;
      end else begin
        div_s = div_r;
      end
    end else begin
      count_s = count_r + CNT_W'(1);
      sq_s    = ({1'b0, count_s} >= half_s);
    end
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= CNT_W'(DEFAULT_DIV);
      count_r <= '0;
      tick_r  <= 1'b0;
      sq_r    <= 1'b0;
    end else begin
      div_r   <= div_s;
      count_r <= count_s;
      tick_r  <= tick_s;
      sq_r    <= sq_s;
    end
  end

  assign tick = tick_r;
  assign sq   = sq_r;

endmodule

// File: rtl/clk_div_bank.sv
// NUM_CH programmable clock-enable generators with a single-slot, glitch-free retune port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [cfg_ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             sq
);

  localparam int CH_W = cfg_ch_w(NUM_CH);

  logic              pend_r, ready_r;
  logic [CH_W-1:0]   pend_ch_r;
  logic [CNT_W-1:0]  pend_div_r;
  logic              accept_s, valid_ch_s, now_s, commit_s;
  logic [NUM_CH-1:0] sel_s, wrap_s, idle_s, load_s, load_now_s;

  // Decode the pending target and decide when it commits.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i] = pend_r && (pend_ch_r == CH_W'(i));
    end
    accept_s   = cfg_valid && ready_r;
    valid_ch_s = (int'(cfg_ch) < NUM_CH);
    // Enabling from or disabling to zero needs no period boundary to stay glitch-free.
    now_s      = pend_r && ((|(sel_s & idle_s)) || (pend_div_r == CNT_W'(DIV_OFF)));
    commit_s   = pend_r && (sync || now_s || (|(sel_s & wrap_s)));
    if (now_s) begin
      load_s     = '0;
      load_now_s = sel_s;
    end else begin
      load_s     = sel_s;
      load_now_s = '0;
    end
  end

  // Pending slot and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r     <= 1'b0;
      pend_ch_r  <= '0;
      pend_div_r <= '0;
      ready_r    <= 1'b1;
    end else if (accept_s) begin
      pend_r     <= valid_ch_s;
      pend_ch_r  <= cfg_ch;
      pend_div_r <= cfg_div;
      ready_r    <= 1'b0;
    end else if (commit_s) begin
      pend_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      ready_r    <= !pend_r;
    end
  end

  assign cfg_ready = ready_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync     (sync),
      .load     (load_s[g]),
      .load_now (load_now_s[g]),
      .new_div  (pend_div_r),
      .tick     (tick[g]),
      .sq       (sq[g]),
      .wrap     (wrap_s[g]),
      .idle     (idle_s[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: hand-derived tick/sq/cfg_ready sequences per scenario.
module tb_clk_div_bank;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n, sync, cfg_valid, cfg_ready;
  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick, sq;

  int n_tests = 0;
  int n_fail  = 0;
  int bdiv [NUM_CH];

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and park on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected vectors j edges after all counters were last aligned to 0.
  function automatic logic [NUM_CH-1:0] model_tick(input int j);
    for (int c = 0; c < NUM_CH; c++) begin
      model_tick[c] = (bdiv[c] != 0) && (j > 0) && ((j % bdiv[c]) == 0);
    end
  endfunction

  function automatic logic [NUM_CH-1:0] model_sq(input int j);
    for (int c = 0; c < NUM_CH; c++) begin
      model_sq[c] = (bdiv[c] != 0) && ((j % bdiv[c]) >= ((bdiv[c] + 1) / 2));
    end
  endfunction

  task automatic check_aligned(input string tag, input int j);
    check_eq({tag, "_tick"}, 32'(tick), 32'(model_tick(j)));
    check_eq({tag, "_sq"},   32'(sq),   32'(model_sq(j)));
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_div = 16'd0;
    for (int c = 0; c < NUM_CH; c++) bdiv[c] = 2;

    // Reset state and default divide-by-2.
    repeat (2) @(negedge clk);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_sq", 32'(sq), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      check_aligned("t1", j);
    end
    check_eq("t1_ready", 32'(cfg_ready), 32'd1);

    // Retune ch1 to 5 mid-period: commits on its wrap at edge 8.
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd5;
    step();
    check_eq("t2_ready_low", 32'(cfg_ready), 32'd0);
    check_eq("t2_tick_pre", 32'(tick[1]), 32'd0);
    cfg_valid = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      step();
      if (j == 0) check_eq("t2_ready_high", 32'(cfg_ready), 32'd1);
      check_eq("t2_tick1", 32'(tick[1]), 32'((j % 5) == 0));
      check_eq("t2_sq1", 32'(sq[1]), 32'((j % 5) >= 3));
      check_eq("t2_tick0", 32'(tick[0]), 32'((j % 2) == 0));
    end

    // Disable ch2, hold, then enable with div 3.
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd0;
    step();
    check_eq("t3_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step();
    check_eq("t3_off_ready", 32'(cfg_ready), 32'd1);
    check_eq("t3_off_tick", 32'(tick[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t3_held", 32'({tick[2], sq[2]}), 32'd0);
    end
    cfg_valid = 1'b1; cfg_div = 16'd3;
    step();
    check_eq("t3_en_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step();
    check_eq("t3_en_ready", 32'(cfg_ready), 32'd1);
    check_eq("t3_en_commit", 32'({tick[2], sq[2]}), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      step();
      check_eq("t3_tick2", 32'(tick[2]), 32'((j % 3) == 0));
      check_eq("t3_sq2", 32'(sq[2]), 32'((j % 3) == 2));
    end

    // ch3 to 8, then 8 -> 4 left pending until sync commits it.
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 16'd8;
    step();
    cfg_valid = 1'b0;
    step();
    check_eq("t4_commit8_tick", 32'(tick[3]), 32'd1);
    check_eq("t4_commit8_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_div = 16'd4;
    step();
    check_eq("t4_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    step();
    check_eq("t4_still_pending", 32'(cfg_ready), 32'd0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check_eq("t4_sync_tick", 32'(tick), 32'd0);
    check_eq("t4_sync_sq", 32'(sq), 32'd0);
    check_eq("t4_sync_ready", 32'(cfg_ready), 32'd1);
    bdiv[0] = 2; bdiv[1] = 5; bdiv[2] = 3; bdiv[3] = 4; bdiv[4] = 2;
    for (int j = 1; j <= 8; j++) begin
      step();
      check_aligned("t4", j);
    end

    // Out-of-range channel held on valid: accepted and dropped each time.
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd7;
    for (int j = 9; j <= 16; j++) begin
      step();
      check_eq("t5_ready", 32'(cfg_ready), 32'((j % 2) == 0));
      check_aligned("t5", j);
    end
    cfg_valid = 1'b0;

    // Async reset with an update to ch1 pending.
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd9;
    step();
    check_eq("t6_ready_low", 32'(cfg_ready), 32'd0);
    check_aligned("t6_pre17", 17);
    cfg_valid = 1'b0;
    step();
    check_eq("t6_pending", 32'(cfg_ready), 32'd0);
    check_aligned("t6_pre18", 18);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_tick", 32'(tick), 32'd0);
    check_eq("t6_async_sq", 32'(sq), 32'd0);
    check_eq("t6_async_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) bdiv[c] = 2;
    for (int j = 1; j <= 6; j++) begin
      step();
      check_aligned("t6_post", j);
      check_eq("t6_post_ready", 32'(cfg_ready), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
